// File: rtl/raster_dcr_shadow.sv
// raster_dcr_shadow
//   Double-buffered DCR stage for the raster unit. Host DCR writes update a
//   staging register set; a write to the COMMIT address snapshots the staging
//   set into a NUM_SLOTS-deep circular queue. The raster unit consumes the
//   head snapshot one frame at a time, so the host can program frame N+1
//   while frame N is still rasterising.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   dcr_write_valid/addr/data   host DCR write bus (one write per cycle)
//   raster_*              head snapshot fields, all-zero while the queue is empty
//   dcrs_valid            queue non-empty, head presented on raster_*
//   dcrs_pop              consumer releases the head (ignored when empty)
//   pending_count         number of queued snapshots
//   overflow              sticky, set when a commit is dropped on a full queue
//
// Build options
//   RASTER_DCR_AUTOCOMMIT_EN  a write to SCISSOR_Y also commits, with the new
//                             ymin/ymax merged into the pushed snapshot.

module raster_dcr_shadow #(
  parameter string INSTANCE_ID = "",
  parameter int    NUM_SLOTS   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dcr_write_valid,
  input  logic [11:0]                  dcr_write_addr,
  input  logic [31:0]                  dcr_write_data,
  output logic [31:0]                  raster_tbuf_addr,
  output logic [15:0]                  raster_tile_count,
  output logic [31:0]                  raster_pbuf_addr,
  output logic [15:0]                  raster_pbuf_stride,
  output logic [11:0]                  raster_dst_xmin,
  output logic [11:0]                  raster_dst_xmax,
  output logic [11:0]                  raster_dst_ymin,
  output logic [11:0]                  raster_dst_ymax,
  output logic                         dcrs_valid,
  input  logic                         dcrs_pop,
  output logic [$clog2(NUM_SLOTS):0]   pending_count,
  output logic                         overflow
);

  localparam int RASTER_ADDR_BITS      = 32;
  localparam int RASTER_TILE_BITS      = 16;
  localparam int VX_RASTER_STRIDE_BITS = 16;
  localparam int RASTER_DIM_BITS       = 12;
  localparam int PTR_W                 = $clog2(NUM_SLOTS);
  localparam int CNT_W                 = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NUM_SLOTS);

  localparam logic [11:0] VX_DCR_RASTER_TBUF_ADDR   = 12'h010;
  localparam logic [11:0] VX_DCR_RASTER_TILE_COUNT  = 12'h011;
  localparam logic [11:0] VX_DCR_RASTER_PBUF_ADDR   = 12'h012;
  localparam logic [11:0] VX_DCR_RASTER_PBUF_STRIDE = 12'h013;
  localparam logic [11:0] VX_DCR_RASTER_SCISSOR_X   = 12'h014;
  localparam logic [11:0] VX_DCR_RASTER_SCISSOR_Y   = 12'h015;
  localparam logic [11:0] VX_DCR_RASTER_COMMIT      = 12'h016;

  typedef struct packed {
    logic [RASTER_ADDR_BITS-1:0]      tbuf_addr;
    logic [RASTER_TILE_BITS-1:0]      tile_count;
    logic [RASTER_ADDR_BITS-1:0]      pbuf_addr;
    logic [VX_RASTER_STRIDE_BITS-1:0] pbuf_stride;
    logic [RASTER_DIM_BITS-1:0]       dst_xmin;
    logic [RASTER_DIM_BITS-1:0]       dst_xmax;
    logic [RASTER_DIM_BITS-1:0]       dst_ymin;
    logic [RASTER_DIM_BITS-1:0]       dst_ymax;
  } snap_t;

  snap_t             stg_q, stg_d;
  snap_t             slot_q [NUM_SLOTS];
  snap_t             slot_d [NUM_SLOTS];
  snap_t             head;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              commit_req, push_ok, pop_ok;

  // Staging decode. The pushed snapshot is taken from stg_d so that an
  // autocommit on SCISSOR_Y carries the y bounds written in the same cycle;
  // for a plain COMMIT stg_d equals stg_q.
  always_comb begin
    stg_d      = stg_q;
    commit_req = 1'b0;
    if (dcr_write_valid) begin
      case (dcr_write_addr)
        VX_DCR_RASTER_TBUF_ADDR:   stg_d.tbuf_addr   = dcr_write_data[RASTER_ADDR_BITS-1:0];
        VX_DCR_RASTER_TILE_COUNT:  stg_d.tile_count  = dcr_write_data[RASTER_TILE_BITS-1:0];
        VX_DCR_RASTER_PBUF_ADDR:   stg_d.pbuf_addr   = dcr_write_data[RASTER_ADDR_BITS-1:0];
        VX_DCR_RASTER_PBUF_STRIDE: stg_d.pbuf_stride = dcr_write_data[VX_RASTER_STRIDE_BITS-1:0];
        VX_DCR_RASTER_SCISSOR_X: begin
          stg_d.dst_xmin = dcr_write_data[0+:RASTER_DIM_BITS];
          stg_d.dst_xmax = dcr_write_data[16+:RASTER_DIM_BITS];
        end
        VX_DCR_RASTER_SCISSOR_Y: begin
          stg_d.dst_ymin = dcr_write_data[0+:RASTER_DIM_BITS];
          stg_d.dst_ymax = dcr_write_data[16+:RASTER_DIM_BITS];
`ifdef RASTER_DCR_AUTOCOMMIT_EN
          commit_req     = 1'b1;
`else
          commit_req     = 1'b0;
`endif
        end
        VX_DCR_RASTER_COMMIT:      commit_req = 1'b1;
        default: ;
      endcase
    end
  end

  // Queue control. A pop on a full queue frees the slot the simultaneous
  // push needs, so the push is accepted and no overflow is flagged.
  always_comb begin
    pop_ok     = dcrs_pop && (count_q != '0);
    push_ok    = commit_req && ((count_q != FULL_COUNT) || pop_ok);
    overflow_d = overflow_q || (commit_req && !push_ok);
    rd_ptr_d   = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d   = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    slot_d     = slot_q;
    if (push_ok) begin
      slot_d[wr_ptr_q] = stg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stg_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      stg_q      <= stg_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Slot storage needs no reset: it is only observed through the head mux,
  // which is gated by a non-zero count.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  always_comb begin
    head = '0;
    if (count_q != '0) begin
      head = slot_q[rd_ptr_q];
    end
  end

  assign dcrs_valid         = (count_q != '0);
  assign pending_count      = count_q;
  assign overflow           = overflow_q;
  assign raster_tbuf_addr   = head.tbuf_addr;
  assign raster_tile_count  = head.tile_count;
  assign raster_pbuf_addr   = head.pbuf_addr;
  assign raster_pbuf_stride = head.pbuf_stride;
  assign raster_dst_xmin    = head.dst_xmin;
  assign raster_dst_xmax    = head.dst_xmax;
  assign raster_dst_ymin    = head.dst_ymin;
  assign raster_dst_ymax    = head.dst_ymax;

endmodule

// File: tb/tb_raster_dcr_shadow.sv
// Testbench for raster_dcr_shadow: directed scenarios followed by random DCR
// traffic, all checked against a queue-based reference model.

module tb_raster_dcr_shadow;

  localparam int NUM_SLOTS = 2;

  localparam logic [11:0] A_TBUF   = 12'h010;
  localparam logic [11:0] A_TILE   = 12'h011;
  localparam logic [11:0] A_PBUF   = 12'h012;
  localparam logic [11:0] A_STRIDE = 12'h013;
  localparam logic [11:0] A_SCX    = 12'h014;
  localparam logic [11:0] A_SCY    = 12'h015;
  localparam logic [11:0] A_COMMIT = 12'h016;
  localparam logic [11:0] A_BOGUS  = 12'h0FF;

  typedef struct {
    logic [31:0] tbuf;
    logic [15:0] tile;
    logic [31:0] pbuf;
    logic [15:0] stride;
    logic [11:0] xmin, xmax, ymin, ymax;
  } frame_t;

  logic        clk;
  logic        reset;
  logic        wv;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic        pop;
  logic [31:0] tbuf_o, pbuf_o;
  logic [15:0] tile_o, stride_o;
  logic [11:0] xmin_o, xmax_o, ymin_o, ymax_o;
  logic        valid_o;
  logic [1:0]  count_o;
  logic        ovf_o;

  raster_dcr_shadow #(.INSTANCE_ID("tb"), .NUM_SLOTS(NUM_SLOTS)) dut (
    .clk                (clk),
    .reset              (reset),
    .dcr_write_valid    (wv),
    .dcr_write_addr     (waddr),
    .dcr_write_data     (wdata),
    .raster_tbuf_addr   (tbuf_o),
    .raster_tile_count  (tile_o),
    .raster_pbuf_addr   (pbuf_o),
    .raster_pbuf_stride (stride_o),
    .raster_dst_xmin    (xmin_o),
    .raster_dst_xmax    (xmax_o),
    .raster_dst_ymin    (ymin_o),
    .raster_dst_ymax    (ymax_o),
    .dcrs_valid         (valid_o),
    .dcrs_pop           (pop),
    .pending_count      (count_o),
    .overflow           (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  frame_t stg;
  frame_t fifo[$];
  bit     ovf_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    frame_t h;
    h = '{default: '0};
    if (fifo.size() != 0) h = fifo[0];
    chk("dcrs_valid",    64'(valid_o), 64'(fifo.size() != 0));
    chk("pending_count", 64'(count_o), 64'(fifo.size()));
    chk("overflow",      64'(ovf_o),   64'(ovf_m));
    chk("tbuf_addr",     64'(tbuf_o),  64'(h.tbuf));
    chk("tile_count",    64'(tile_o),  64'(h.tile));
    chk("pbuf_addr",     64'(pbuf_o),  64'(h.pbuf));
    chk("pbuf_stride",   64'(stride_o), 64'(h.stride));
    chk("scissor_x",     {40'd0, xmin_o, xmax_o}, {40'd0, h.xmin, h.xmax});
    chk("scissor_y",     {40'd0, ymin_o, ymax_o}, {40'd0, h.ymin, h.ymax});
  endtask

  task automatic model_reset();
    stg   = '{default: '0};
    fifo.delete();
    ovf_m = 1'b0;
  endtask

  // One clock of the reference: staging update, then release of the head,
  // then an append if room remains.
  task automatic model_step(input bit w, input logic [11:0] a, input logic [31:0] d, input bit p);
    bit push;
    push = 1'b0;
    if (w) begin
      case (a)
        A_TBUF:   stg.tbuf   = d;
        A_TILE:   stg.tile   = d[15:0];
        A_PBUF:   stg.pbuf   = d;
        A_STRIDE: stg.stride = d[15:0];
        A_SCX:    begin stg.xmin = d[11:0]; stg.xmax = d[27:16]; end
        A_SCY: begin
          stg.ymin = d[11:0];
          stg.ymax = d[27:16];
`ifdef RASTER_DCR_AUTOCOMMIT_EN
          push = 1'b1;
`endif
        end
        A_COMMIT: push = 1'b1;
        default: ;
      endcase
    end
    if (p && fifo.size() != 0) fifo.delete(0);
    if (push) begin
      if (fifo.size() < NUM_SLOTS) fifo.push_back(stg);
      else ovf_m = 1'b1;
    end
  endtask

  task automatic cycle(input bit w, input logic [11:0] a, input logic [31:0] d, input bit p);
    wv = w; waddr = a; wdata = d; pop = p;
    @(posedge clk);
    model_step(w, a, d, p);
    #1;
    wv = 1'b0; pop = 1'b0;
    check_all();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    cycle(1'b1, a, d, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; wv = 1'b0; pop = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    reset = 1'b1; wv = 1'b0; waddr = '0; wdata = '0; pop = 1'b0;
    model_reset();
    do_reset();

    // First frame: registered one-cycle latency
    wr(A_TBUF, 32'h0000_1000);
    wr(A_TILE, 32'd4);
    wr(A_COMMIT, 32'hDEAD_BEEF);
    chk("tp1_valid", 64'(valid_o), 64'd1);
    chk("tp1_tbuf",  64'(tbuf_o),  64'h1000);
    chk("tp1_tile",  64'(tile_o),  64'd4);
    chk("tp1_count", 64'(count_o), 64'd1);

    // Overflow on third commit; dropped snapshot never appears
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      wr(A_TILE, 32'(i));
      wr(A_COMMIT, 32'd0);
    end
    chk("ovf_count", 64'(count_o), 64'd2);
    chk("ovf_flag",  64'(ovf_o),   64'd1);
    chk("ovf_head1", 64'(tile_o),  64'd1);
    cycle(1'b0, 12'h0, 32'h0, 1'b1);
    chk("ovf_head2", 64'(tile_o),  64'd2);
    cycle(1'b0, 12'h0, 32'h0, 1'b1);
    chk("ovf_empty", 64'(valid_o), 64'd0);

    // Full queue, commit and pop together
    do_reset();
    for (int i = 1; i <= 2; i++) begin
      wr(A_TILE, 32'(i));
      wr(A_COMMIT, 32'd0);
    end
    wr(A_TILE, 32'd3);
    cycle(1'b1, A_COMMIT, 32'd0, 1'b1);
    chk("fullpp_ovf",   64'(ovf_o),   64'd0);
    chk("fullpp_count", 64'(count_o), 64'd2);
    chk("fullpp_head",  64'(tile_o),  64'd2);
    cycle(1'b0, 12'h0, 32'h0, 1'b1);
    chk("fullpp_tail",  64'(tile_o),  64'd3);

    // Pop on empty queue
    do_reset();
    cycle(1'b0, 12'h0, 32'h0, 1'b1);
    chk("uflow_valid", 64'(valid_o), 64'd0);
    chk("uflow_count", 64'(count_o), 64'd0);

    // SCISSOR_Y write
    do_reset();
    wr(A_SCY, 32'h00F0_0010);
`ifdef RASTER_DCR_AUTOCOMMIT_EN
    chk("auto_ymin", 64'(ymin_o), 64'h10);
    chk("auto_ymax", 64'(ymax_o), 64'hF0);
`else
    chk("noauto_valid", 64'(valid_o), 64'd0);
`endif

    // Reset with two queued and overflow set clears everything, staging too
    do_reset();
    wr(A_TBUF, 32'hCAFE_0000);
    wr(A_TILE, 32'd9);
    for (int i = 0; i < 3; i++) wr(A_COMMIT, 32'd0);
    chk("pre_rst_ovf", 64'(ovf_o), 64'd1);
    do_reset();
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ovf",   64'(ovf_o),   64'd0);
    wr(A_COMMIT, 32'd0);
    chk("rst_commit_valid", 64'(valid_o), 64'd1);
    chk("rst_commit_tbuf",  64'(tbuf_o),  64'd0);
    chk("rst_commit_tile",  64'(tile_o),  64'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [11:0] a;
      int sel;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        sel = $urandom_range(0, 9);
        case (sel)
          0: a = A_TBUF;
          1: a = A_TILE;
          2: a = A_PBUF;
          3: a = A_STRIDE;
          4: a = A_SCX;
          5: a = A_SCY;
          6: a = A_BOGUS;
          default: a = A_COMMIT;
        endcase
        cycle(($urandom_range(0, 9) < 7), a, $urandom(), ($urandom_range(0, 9) < 3));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
